// File: rtl/kairo_uart_busmaster.sv
// kairo_uart_busmaster: UART 8N1 command port that issues single-word valid/ready bus reads and writes
module kairo_uart_busmaster #(
  parameter int CLKS_PER_BIT = 868,
  parameter int BUS_TIMEOUT  = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        M_VALID,
  input  logic        M_READY,
  output logic [3:0]  M_WSTB,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  input  logic [31:0] M_RDATA,
  input  logic        M_EXCEPT,
  output logic        BUSY
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int TW = $clog2(BUS_TIMEOUT) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(BUS_TIMEOUT - 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {C_IDLE, C_ADDR, C_DATA, C_BUS, C_RESP} cmd_state_t;

  rx_state_t   rx_st;
  cmd_state_t  cst;
  logic        rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_valid, rx_ferr;
  logic        tx_act;
  logic [CW-1:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [8:0]  tx_sh;
  logic        tx_done;
  logic        wr;
  logic [1:0]  bcnt;
  logic [TW-1:0] tcnt;
  logic [23:0] rbuf;
  logic [1:0]  left;
  logic        bad_cmd, bus_done, bus_to, next_resp, load;
  logic [7:0]  load_byte;

  assign BUSY      = cst != C_IDLE;
  assign tx_done   = tx_act && tx_cnt == C_LAST && tx_bit == 4'd9;
  assign bad_cmd   = cst == C_IDLE && rx_valid && rx_sh != CMD_W && rx_sh != CMD_R;
  assign bus_done  = cst == C_BUS && M_READY;
  assign bus_to    = cst == C_BUS && !M_READY && tcnt == T_LAST;
  assign next_resp = cst == C_RESP && tx_done && left != 2'd0;
  assign load      = bad_cmd || bus_done || bus_to || next_resp;
  assign load_byte = next_resp ? rbuf[23:16] : (bus_done && !M_EXCEPT) ? (wr ? ACK : M_RDATA[31:24]) : NAK;

  // Receiver: synchronise the line, qualify the start bit at mid-bit, sample data and stop at bit centres
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_st    <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= UART_RX;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_st)
        R_IDLE: if (rx_s3 && !rx_s2) begin
          rx_st  <= R_START;
          rx_cnt <= '0;
        end
        R_START: if (rx_cnt == C_HALF) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s2 ? R_IDLE : R_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        R_DATA: if (rx_cnt == C_LAST) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_st <= R_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        R_STOP: if (rx_cnt == C_LAST) begin
          rx_cnt   <= '0;
          rx_st    <= R_IDLE;
          rx_valid <= rx_s2;
          rx_ferr  <= !rx_s2;
        end else rx_cnt <= rx_cnt + 1'b1;
      endcase
    end
  end

  // Transmitter: a load restarts the frame immediately, so consecutive bytes run with no idle gap
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      UART_TX <= 1'b1;
      tx_act  <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
    end else if (load) begin
      UART_TX <= 1'b0;
      tx_sh   <= {1'b1, load_byte};
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_act  <= 1'b1;
    end else if (tx_act) begin
      if (tx_cnt == C_LAST) begin
        tx_cnt  <= '0;
        tx_bit  <= tx_bit + 1'b1;
        UART_TX <= tx_sh[0];
        tx_sh   <= {1'b1, tx_sh[8:1]};
        tx_act  <= tx_bit != 4'd9;
      end else tx_cnt <= tx_cnt + 1'b1;
    end
  end

  // Command sequencer: parse the frame, run one bus transaction, then stream the response bytes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cst     <= C_IDLE;
      M_VALID <= 1'b0;
      M_WSTB  <= 4'h0;
      M_ADDR  <= '0;
      M_WDATA <= '0;
      wr      <= 1'b0;
      bcnt    <= '0;
      tcnt    <= '0;
      rbuf    <= '0;
      left    <= '0;
    end else begin
      case (cst)
        C_IDLE: if (rx_valid) begin
          bcnt <= '0;
          left <= '0;
          wr   <= rx_sh == CMD_W;
          cst  <= (rx_sh == CMD_W || rx_sh == CMD_R) ? C_ADDR : C_RESP;
        end
        C_ADDR: if (rx_ferr) cst <= C_IDLE;
        else if (rx_valid) begin
          M_ADDR <= {M_ADDR[23:0], rx_sh};
          bcnt   <= bcnt + 1'b1;
          tcnt   <= '0;
          if (bcnt == 2'd3) begin
            cst     <= wr ? C_DATA : C_BUS;
            M_VALID <= !wr;
          end
        end
        C_DATA: if (rx_ferr) cst <= C_IDLE;
        else if (rx_valid) begin
          M_WDATA <= {M_WDATA[23:0], rx_sh};
          bcnt    <= bcnt + 1'b1;
          tcnt    <= '0;
          if (bcnt == 2'd3) begin
            cst     <= C_BUS;
            M_VALID <= 1'b1;
            M_WSTB  <= 4'hF;
          end
        end
        C_BUS: begin
          tcnt <= tcnt + 1'b1;
          if (M_READY || tcnt == T_LAST) begin
            M_VALID <= 1'b0;
            M_WSTB  <= 4'h0;
            cst     <= C_RESP;
            rbuf    <= M_RDATA[23:0];
            left    <= (M_READY && !M_EXCEPT && !wr) ? 2'd3 : 2'd0;
          end
        end
        C_RESP: if (tx_done) begin
          if (left == 2'd0) cst <= C_IDLE;
          else begin
            left <= left - 1'b1;
            rbuf <= {rbuf[15:0], 8'h00};
          end
        end
        default: cst <= C_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kairo_uart_busmaster.sv
// tb_kairo_uart_busmaster: directed scoreboard bench for the UART bus initiator
module tb_kairo_uart_busmaster;
  localparam int CPB = 4;
  localparam int BT  = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        UART_RX = 1'b1;
  logic        UART_TX;
  logic        M_VALID;
  logic        M_READY = 1'b0;
  logic [3:0]  M_WSTB;
  logic [31:0] M_ADDR;
  logic [31:0] M_WDATA;
  logic [31:0] M_RDATA = '0;
  logic        M_EXCEPT = 1'b0;
  logic        BUSY;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int nvalid = 0;
  logic [7:0]  exp_tx[$];
  logic [67:0] exp_bus[$];
  int          starts[$];

  kairo_uart_busmaster #(.CLKS_PER_BIT(CPB), .BUS_TIMEOUT(BT)) dut (
    .CLK(CLK), .RST(RST), .UART_RX(UART_RX), .UART_TX(UART_TX),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_WSTB(M_WSTB), .M_ADDR(M_ADDR),
    .M_WDATA(M_WDATA), .M_RDATA(M_RDATA), .M_EXCEPT(M_EXCEPT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin : valid_mon
    bit pv;
    pv = 0;
    forever begin
      @(negedge CLK);
      if (M_VALID === 1'b1 && !pv) nvalid++;
      pv = M_VALID === 1'b1;
    end
  end

  initial begin : tx_mon
    int ph;
    logic [7:0] b;
    bit infr;
    ph = 0;
    b = '0;
    infr = 0;
    forever begin
      @(negedge CLK);
      if (RST) infr = 0;
      else if (!infr) begin
        if (UART_TX === 1'b0) begin
          infr = 1;
          ph = 0;
          starts.push_back(cyc);
        end
      end else begin
        ph++;
        if (ph >= 5 && ph <= 33 && ph % 4 == 1) b[(ph - 5) / 4] = UART_TX;
        if (ph == 37) begin
          infr = 0;
          check("tx_stop", UART_TX, 1);
          check("tx_pending", exp_tx.size() != 0, 1);
          if (exp_tx.size() != 0) check("tx_byte", b, exp_tx.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART_RX = f[i];
      repeat (CPB) @(negedge CLK);
    end
    UART_RX = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d, input bit w);
    send_byte(c);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    if (w) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    while (M_VALID !== 1'b1 && t < 400) begin
      @(negedge CLK);
      t++;
    end
    check({tag, "_valid_seen"}, M_VALID, 1);
  endtask

  task automatic bus_respond(input int delay, input logic exc, input logic [31:0] rd, input string tag);
    logic [67:0] e;
    e = exp_bus.pop_front();
    wait_valid(tag);
    if (M_VALID !== 1'b1) return;
    for (int k = 1; k <= delay; k++) begin
      check({tag, "_req"}, {M_VALID, M_WSTB, M_ADDR, (e[67:64] == 4'hF) ? M_WDATA : 32'h0}, {1'b1, e});
      if (k == delay) begin
        M_READY = 1'b1;
        M_EXCEPT = exc;
        M_RDATA = rd;
      end
      @(negedge CLK);
    end
    M_READY = 1'b0;
    M_EXCEPT = 1'b0;
    M_RDATA = '0;
    check({tag, "_released"}, {M_VALID, M_WSTB}, 0);
    check({tag, "_resp_start"}, UART_TX, 0);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || BUSY !== 1'b0) && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    check({tag, "_drained"}, {exp_tx.size() == 0, BUSY}, 2'b10);
    repeat (4) @(negedge CLK);
  endtask

  initial begin : main
    int n;
    int nv;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {UART_TX, M_VALID, M_WSTB, M_ADDR, M_WDATA, BUSY}, {1'b1, 70'h0});
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    exp_bus.push_back({4'hF, 32'h10000040, 32'hDEADBEEF});
    exp_tx.push_back(8'h06);
    send_cmd(8'h57, 32'h10000040, 32'hDEADBEEF, 1);
    bus_respond(3, 1'b0, 32'h0, "wr");
    wait_drain("wr");

    starts.delete();
    exp_bus.push_back({4'h0, 32'h80020004, 32'h0});
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h78);
    send_cmd(8'h52, 32'h80020004, 32'h0, 0);
    bus_respond(1, 1'b0, 32'h12345678, "rd");
    wait_drain("rd");
    check("rd_frames", starts.size(), 4);
    if (starts.size() == 4) for (int i = 1; i < 4; i++) check("rd_gap", starts[i] - starts[i-1], 10 * CPB);

    exp_bus.push_back({4'h0, 32'h00000100, 32'h0});
    exp_tx.push_back(8'h15);
    send_cmd(8'h52, 32'h00000100, 32'h0, 0);
    bus_respond(2, 1'b1, 32'hCAFEF00D, "exc");
    wait_drain("exc");

    exp_tx.push_back(8'h15);
    send_cmd(8'h52, 32'h00000044, 32'h0, 0);
    wait_valid("to");
    check("to_req", {M_WSTB, M_ADDR}, {4'h0, 32'h44});
    n = 0;
    while (M_VALID === 1'b1 && n < 100) begin
      n++;
      @(negedge CLK);
    end
    check("to_valid_cycles", n, BT);
    check("to_resp_start", UART_TX, 0);
    M_READY = 1'b1;
    @(negedge CLK);
    M_READY = 1'b0;
    wait_drain("to");

    exp_tx.push_back(8'h15);
    send_byte(8'h41);
    wait_drain("badcmd");

    nv = nvalid;
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00, 1'b0);
    repeat (6) @(negedge CLK);
    check("ferr_busy", BUSY, 0);
    check("ferr_no_bus", nvalid, nv);
    exp_bus.push_back({4'hF, 32'h20000008, 32'h0BADF00D});
    exp_tx.push_back(8'h06);
    send_cmd(8'h57, 32'h20000008, 32'h0BADF00D, 1);
    bus_respond(1, 1'b0, 32'h0, "ferr_wr");
    wait_drain("ferr_wr");

    nv = nvalid;
    UART_RX = 1'b0;
    @(negedge CLK);
    UART_RX = 1'b1;
    repeat (60) @(negedge CLK);
    check("glitch_busy", BUSY, 0);
    check("glitch_no_bus", nvalid, nv);

    send_cmd(8'h52, 32'h00000030, 32'h0, 0);
    wait_valid("rst_bus");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rst_bus_outputs", {UART_TX, M_VALID, M_WSTB, BUSY}, {1'b1, 1'b0, 4'h0, 1'b0});
    @(negedge CLK);
    RST = 1'b0;
    nv = nvalid;
    repeat (60) @(negedge CLK);
    check("rst_bus_no_txn", nvalid, nv);
    check("rst_bus_idle", {UART_TX, BUSY}, 2'b10);

    send_byte(8'h41);
    n = 0;
    while (UART_TX !== 1'b0 && n < 100) begin
      n++;
      @(negedge CLK);
    end
    check("rst_tx_started", UART_TX, 0);
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rst_tx_outputs", {UART_TX, M_VALID, BUSY}, 3'b100);
    @(negedge CLK);
    RST = 1'b0;
    repeat (60) @(negedge CLK);
    check("rst_tx_idle", {UART_TX, BUSY}, 2'b10);

    nv = nvalid;
    exp_bus.push_back({4'hF, 32'h00001000, 32'h11112222});
    exp_bus.push_back({4'hF, 32'h00001004, 32'h33334444});
    exp_tx.push_back(8'h06);
    exp_tx.push_back(8'h06);
    send_cmd(8'h57, 32'h00001000, 32'h11112222, 1);
    bus_respond(2, 1'b0, 32'h0, "b2b1");
    n = 0;
    while (exp_tx.size() != 1 && n < 200) begin
      n++;
      @(negedge CLK);
    end
    check("b2b1_ack", exp_tx.size(), 1);
    repeat (3) @(negedge CLK);
    send_cmd(8'h57, 32'h00001004, 32'h33334444, 1);
    bus_respond(2, 1'b0, 32'h0, "b2b2");
    wait_drain("b2b2");
    check("b2b_txn_count", nvalid - nv, 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
